// File: rtl/sm_ahb_req_capture.sv
// AHB-Lite slave front-end for schoolMIPS peripherals: decodes address-phase
// requests, presents a simple pm valid/we/addr/wd interface and inserts one
// wait state after every write to resolve read-after-write hazards.

// Clear-only register: captures d every cycle, resets to 0.
module sm_register_c #(
   parameter int unsigned W = 1
) (
   input  logic         a_clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Unconditional capture with asynchronous clear
   always_ff @(posedge a_clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= d;
   end

endmodule

// Write-enable register: captures d only when en is high, resets to 0.
module sm_register_we #(
   parameter int unsigned W = 1
) (
   input  logic         a_clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Enabled capture with asynchronous clear
   always_ff @(posedge a_clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (en) q <= d;
   end

endmodule

module sm_ahb_req_capture #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              a_clk,
   input  logic              rst_n,
   input  logic              hsel,
   input  logic              hwrite,
   input  logic              hready,
   input  logic [1:0]        htrans,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [DATA_W-1:0] hwdata,
   output logic              hreadyout,
   output logic              hresp,
   output logic              pm_valid,
   output logic              pm_we,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [DATA_W-1:0] pm_wd
);

   localparam logic [1:0] HTRANS_IDLE = 2'b00;

   logic              request;
   logic              request_r;
   logic              request_w_new;
   logic              request_w;
   logic              hz_raw_d;
   logic              hz_raw;
   logic [ADDR_W-1:0] addr_w;

   // Address-phase decode
   always_comb begin
      request       = hready & hsel & (htrans != HTRANS_IDLE);
      request_r     = request & ~hwrite;
      request_w_new = request & hwrite;
      // A read colliding with a write data phase must be held off one cycle
      hz_raw_d      = (request_r & request_w) | request_w_new;
   end

   // Write data-phase flag: high for the one cycle after a write address phase
   sm_register_c #(.W(1)) u_request_w (
      .a_clk (a_clk),
      .rst_n (rst_n),
      .d     (request_w_new),
      .q     (request_w)
   );

   // Address latch, refreshed on every accepted request
   sm_register_we #(.W(ADDR_W)) u_addr_w (
      .a_clk (a_clk),
      .rst_n (rst_n),
      .en    (request),
      .d     (haddr),
      .q     (addr_w)
   );

   // Hazard flag driving the wait state
   sm_register_c #(.W(1)) u_hz_raw (
      .a_clk (a_clk),
      .rst_n (rst_n),
      .d     (hz_raw_d),
      .q     (hz_raw)
   );

   // Peripheral and bus response outputs; a pending write owns the address
   always_comb begin
      pm_we     = request_w;
      pm_wd     = hwdata;
      pm_addr   = request_w ? addr_w : haddr;
      pm_valid  = request_r | request_w;
      hreadyout = ~hz_raw;
      hresp     = 1'b0;
   end

endmodule

// File: tb/tb_sm_ahb_req_capture.sv
// Directed bench for sm_ahb_req_capture: reset, a table of single-cycle
// vectors with hand-computed expectations, and async reset mid-write.
module tb_sm_ahb_req_capture;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NVEC   = 17;

   logic              a_clk;
   logic              rst_n;
   logic              hsel;
   logic              hwrite;
   logic              hready;
   logic [1:0]        htrans;
   logic [ADDR_W-1:0] haddr;
   logic [DATA_W-1:0] hwdata;
   logic              hreadyout;
   logic              hresp;
   logic              pm_valid;
   logic              pm_we;
   logic [ADDR_W-1:0] pm_addr;
   logic [DATA_W-1:0] pm_wd;

   int checks;
   int errors;

   typedef struct {
      logic              hsel;
      logic              hwrite;
      logic              hready;
      logic [1:0]        htrans;
      logic [ADDR_W-1:0] haddr;
      logic [DATA_W-1:0] hwdata;
      logic              exp_ready;
      logic              exp_valid;
      logic              exp_we;
      logic [ADDR_W-1:0] exp_addr;
   } vec_t;

   vec_t vecs [NVEC];

   sm_ahb_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .a_clk     (a_clk),
      .rst_n     (rst_n),
      .hsel      (hsel),
      .hwrite    (hwrite),
      .hready    (hready),
      .htrans    (htrans),
      .haddr     (haddr),
      .hwdata    (hwdata),
      .hreadyout (hreadyout),
      .hresp     (hresp),
      .pm_valid  (pm_valid),
      .pm_we     (pm_we),
      .pm_addr   (pm_addr),
      .pm_wd     (pm_wd)
   );

   initial a_clk = 1'b0;
   always #5 a_clk = ~a_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic sel, input logic wr, input logic rdy,
                               input logic [1:0] tr, input logic [31:0] a,
                               input logic [31:0] wd, input logic e_rdy,
                               input logic e_val, input logic e_we,
                               input logic [31:0] e_addr);
      vec_t v;
      v.hsel = sel;  v.hwrite = wr;  v.hready = rdy;  v.htrans = tr;
      v.haddr = a;   v.hwdata = wd;
      v.exp_ready = e_rdy; v.exp_valid = e_val; v.exp_we = e_we; v.exp_addr = e_addr;
      return v;
   endfunction

   task automatic drive(input logic sel, input logic wr, input logic rdy,
                        input logic [1:0] tr, input logic [31:0] a, input logic [31:0] wd);
      hsel = sel; hwrite = wr; hready = rdy; htrans = tr; haddr = a; hwdata = wd;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //        sel wr rdy tr     haddr  hwdata  rdy val we addr
      vecs[0]  = mk(0, 0, 1, 2'b00, 32'h8,  32'h0,  1, 0, 0, 32'h8);  // idle
      vecs[1]  = mk(1, 1, 1, 2'b10, 32'h4,  32'h0,  1, 0, 0, 32'h4);  // write addr 0x4
      vecs[2]  = mk(1, 0, 0, 2'b00, 32'h8,  32'hA5, 0, 1, 1, 32'h4);  // data phase
      vecs[3]  = mk(1, 0, 1, 2'b10, 32'h0,  32'h0,  1, 1, 0, 32'h0);  // read 0x0
      vecs[4]  = mk(1, 1, 1, 2'b10, 32'h0,  32'h0,  1, 0, 0, 32'h0);  // write addr 0x0
      vecs[5]  = mk(1, 0, 1, 2'b10, 32'h4,  32'h5A, 0, 1, 1, 32'h0);  // read 0x4 in data phase
      vecs[6]  = mk(1, 0, 0, 2'b10, 32'h4,  32'h0,  0, 0, 0, 32'h4);  // master holds read
      vecs[7]  = mk(1, 0, 1, 2'b10, 32'h4,  32'h0,  1, 1, 0, 32'h4);  // read reissued
      vecs[8]  = mk(1, 1, 1, 2'b00, 32'h8,  32'h0,  1, 0, 0, 32'h8);  // htrans idle
      vecs[9]  = mk(0, 1, 1, 2'b10, 32'h8,  32'h0,  1, 0, 0, 32'h8);  // hsel low
      vecs[10] = mk(1, 1, 0, 2'b10, 32'h8,  32'h0,  1, 0, 0, 32'h8);  // hready low
      vecs[11] = mk(0, 0, 1, 2'b00, 32'hC,  32'h0,  1, 0, 0, 32'hC);  // nothing latched
      vecs[12] = mk(1, 1, 1, 2'b10, 32'h10, 32'h0,  1, 0, 0, 32'h10); // write 0x10
      vecs[13] = mk(1, 1, 0, 2'b10, 32'h14, 32'h66, 0, 1, 1, 32'h10); // 2nd write stalled
      vecs[14] = mk(1, 1, 1, 2'b10, 32'h14, 32'h0,  1, 0, 0, 32'h14); // 2nd write accepted
      vecs[15] = mk(0, 0, 1, 2'b00, 32'h18, 32'h77, 0, 1, 1, 32'h14); // its data phase
      vecs[16] = mk(0, 0, 1, 2'b00, 32'h18, 32'h0,  1, 0, 0, 32'h18); // back to idle

      // Reset held with a write request on the bus
      rst_n = 1'b0;
      drive(1, 1, 1, 2'b10, 32'h20, 32'h0);
      #1;
      check("rst_ready", 32'(hreadyout), 32'h1);
      check("rst_we",    32'(pm_we),     32'h0);
      check("rst_valid", 32'(pm_valid),  32'h0);
      check("rst_addr",  pm_addr,        32'h20);
      check("rst_addr_w", dut.addr_w,    32'h0);
      @(negedge a_clk);
      check("rst_hold_we", 32'(pm_we), 32'h0);
      rst_n = 1'b1;
      @(posedge a_clk); #1;
      check("post_rst_we",    32'(pm_we),     32'h1);
      check("post_rst_ready", 32'(hreadyout), 32'h0);
      check("post_rst_addr",  pm_addr,        32'h20);
      @(negedge a_clk);
      drive(0, 0, 1, 2'b00, 32'h0, 32'h0);
      #1;
      check("post_rst_wait", 32'(hreadyout), 32'h0);

      // Table-driven vectors: drive on negedge, sample before the next posedge
      for (int i = 0; i < int'(NVEC); i++) begin
         @(negedge a_clk);
         drive(vecs[i].hsel, vecs[i].hwrite, vecs[i].hready, vecs[i].htrans,
               vecs[i].haddr, vecs[i].hwdata);
         #1;
         check($sformatf("v%0d_ready", i), 32'(hreadyout), 32'(vecs[i].exp_ready));
         check($sformatf("v%0d_valid", i), 32'(pm_valid),  32'(vecs[i].exp_valid));
         check($sformatf("v%0d_we", i),    32'(pm_we),     32'(vecs[i].exp_we));
         check($sformatf("v%0d_addr", i),  pm_addr,        vecs[i].exp_addr);
         check($sformatf("v%0d_wd", i),    pm_wd,          vecs[i].hwdata);
         check($sformatf("v%0d_hresp", i), 32'(hresp),     32'h0);
         // Gating vectors must leave the latched address at 0x4
         if (i >= 8 && i <= 11)
            check($sformatf("v%0d_addr_w", i), dut.addr_w, 32'h4);
      end

      // Async reset during the wait cycle of a write
      @(negedge a_clk);
      drive(1, 1, 1, 2'b10, 32'h30, 32'h0);
      @(negedge a_clk);
      drive(0, 0, 0, 2'b00, 32'h34, 32'h99);
      #1;
      check("arst_pre_we",    32'(pm_we),     32'h1);
      check("arst_pre_ready", 32'(hreadyout), 32'h0);
      rst_n = 1'b0;
      #1;
      check("arst_ready", 32'(hreadyout), 32'h1);
      check("arst_we",    32'(pm_we),     32'h0);
      check("arst_valid", 32'(pm_valid),  32'h0);
      check("arst_addr",  pm_addr,        32'h34);
      @(negedge a_clk);
      rst_n = 1'b1;
      @(negedge a_clk);
      #1;
      check("arst_dropped_we",    32'(pm_we),     32'h0);
      check("arst_dropped_ready", 32'(hreadyout), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sm_ahb_req_capture.md
Name: sm_ahb_req_capture

Overview:
AHB-Lite slave front-end for schoolMIPS peripherals. It decodes AHB address-phase requests and registers write requests and addresses. It presents a simple peripheral-module (pm) interface: valid, write-enable, address and write-data. It inserts one wait state after every write to resolve read-after-write hazards.
The block is built from two register primitives:
- a clear-only register: captures D every cycle, resets to 0;
- a write-enable register: captures D only when enabled, resets to 0.

Parameters:
- ADDR_W, 32, width of haddr and pm_addr.
- DATA_W, 32, width of hwdata and pm_wd.

Ports:
- a_clk  in  1  bus clock; all registers update on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select.
- hwrite  in  1  1 = write transfer, 0 = read.
- hready  in  1  bus ready (previous transfer complete).
- htrans  in  2  transfer type; 2'b00 = IDLE.
- haddr  in  ADDR_W  address-phase address.
- hwdata  in  DATA_W  data-phase write data.
- hreadyout  out  1  slave ready; 0 = wait state.
- hresp  out  1  response; constant 0 (OKAY).
- pm_valid  out  1  peripheral access strobe (read or write).
- pm_we  out  1  peripheral write enable.
- pm_addr  out  ADDR_W  peripheral address.
- pm_wd  out  DATA_W  peripheral write data.

Behaviour:
Combinational decode:
- request = hready & hsel & (htrans != 2'b00).
- request_r = request & ~hwrite.
- request_w_new = request & hwrite.

Registers (all reset asynchronously to 0 when rst_n = 0; no other reset value):
- request_w: clear-only register, D = request_w_new. It is high for exactly the one cycle after a write address phase (the data phase).
- addr_w: write-enable register, ADDR_W bits, enable = request, D = haddr. It captures on every accepted request, read or write; otherwise it holds its value.
- hz_raw: clear-only register, D = (request_r & request_w) | request_w_new.

Outputs:
- pm_we = request_w.
- pm_wd = hwdata, passed through combinationally, so it is valid in the data phase.
- pm_addr = request_w ? addr_w : haddr. A write uses the latched address; a read uses the live address.
- pm_valid = request_r | request_w.
- hreadyout = ~hz_raw.
- hresp = 0 always.

Required timing:
- Write: the write is performed on the pm interface one cycle after its address phase. hreadyout is 0 during that data-phase cycle, giving exactly one wait state per write.
- Read: pm_valid = 1 in the same cycle as the address phase, with pm_addr = haddr and no wait state.
- Read concurrent with a pending write (request_r & request_w): the write owns pm_addr that cycle and hz_raw is set. The next cycle has hreadyout = 0 so the master reissues/holds the read.
- Back-to-back writes: the second request is not accepted while hreadyout = 0 (hready low). Each write costs 2 cycles.
- Gating: htrans = IDLE, hsel = 0 or hready = 0 produce no request. addr_w holds, and request_w/hz_raw clear on the next edge.

Reset:
- After reset: hreadyout = 1, pm_we = 0, pm_valid = 0, pm_addr = haddr, addr_w = 0.
- Reset asserted mid-write clears request_w and hz_raw immediately (asynchronously); the pending write is dropped.

Width rules: no arithmetic; full-width pass-through. haddr is not decoded inside this block.

Test Plan:
1. Reset: rst_n = 0 with hsel = 1, htrans = 2'b10, hwrite = 1 → hreadyout = 1, pm_we = 0, pm_valid = 0. Release reset; the first edge with request = 1 gives pm_we = 1 next cycle.
2. Single write: hsel = 1, htrans = 2'b10, hwrite = 1, haddr = 0x4, hready = 1 for one cycle, then hwdata = 0xA5 → next cycle pm_we = 1, pm_valid = 1, pm_addr = 0x4, pm_wd = 0xA5, hreadyout = 0. The cycle after: hreadyout = 1, pm_we = 0.
3. Single read: haddr = 0x0, hwrite = 0 → same cycle pm_valid = 1, pm_we = 0, pm_addr = 0x0; hreadyout stays 1.
4. Write at 0x0 followed by a read at 0x4 in the data phase (hready forced 1) → that cycle pm_we = 1, pm_addr = 0x0. The next cycle hreadyout = 0.
5. Idle gating: htrans = 2'b00 (or hsel = 0, or hready = 0) with haddr = 0x8 → pm_valid = 0; addr_w retains its previous value 0x4; no wait state.
6. Async reset during the wait cycle of a write → hreadyout returns to 1 and pm_we goes to 0 before the next a_clk edge.
